// File: rtl/modmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : modmul_arbiter
// Description : Shares one pipelined modular multiplier among NREQ requesters.
//               A round-robin arbiter issues at most one multiplication per
//               cycle. A tag pipeline follows each operation through the
//               multiplier, and the result is steered back to the requester
//               that issued it.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               issue_en        - 1 allows new grants; 0 lets in-flight ops drain
//               req_valid/a/b   - per-requester request, flattened operands
//                                 (requester i uses bits [i*W +: W])
//               req_ready       - one-hot grant (combinational)
//               mm_a/mm_b/mm_d  - modmul operand outputs / result input
//               rsp_valid/rsp_d - one-hot result strobe and result value
//               idle            - nothing in flight and no grant this cycle
// Optional    : define MODMUL_ARB_PERF_EN to add the perf_issues and
//               perf_stall saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module modmul_arbiter #(
    parameter int NREQ   = 4,
    parameter int MM_LAT = 4,
    parameter int W      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mm_a,
    output logic [W-1:0]      mm_b,
    input  logic [W-1:0]      mm_d,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_d,
    output logic              idle
`ifdef MODMUL_ARB_PERF_EN
    ,
    output logic [31:0]       perf_issues,
    output logic [31:0]       perf_stall
`endif
);

    localparam int c_id_w = $clog2(NREQ);

    logic [c_id_w-1:0] r_rr_ptr;
    // Stage 0 travels alongside the registered mm_a/mm_b; stages 1..MM_LAT
    // mirror the multiplier's internal registers, so stage MM_LAT lines up
    // with the cycle in which the matching mm_d is presented.
    logic [MM_LAT:0]   r_tag_vld;
    logic [c_id_w-1:0] r_tag_id [MM_LAT+1];

    logic [c_id_w-1:0] w_grant_idx;
    logic              w_grant_vld;
    logic              w_xfer;
    logic [c_id_w-1:0] w_next_ptr;
    logic [W-1:0]      w_sel_a;
    logic [W-1:0]      w_sel_b;
    logic [NREQ-1:0]   w_rsp_onehot;

    // Round-robin scan. Walking the offsets downward lets the smallest
    // offset (the first requester at or after r_rr_ptr) win.
    always_comb begin : p_arb
        int j;
        j           = 0;
        w_grant_idx = '0;
        w_grant_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req_valid[j]) begin
                w_grant_idx = c_id_w'(j);
                w_grant_vld = 1'b1;
            end
        end
    end

    always_comb begin : p_ready
        req_ready = '0;
        if (issue_en && !rst && w_grant_vld) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_xfer     = |(req_valid & req_ready);
    assign w_next_ptr = (w_grant_idx == c_id_w'(NREQ - 1)) ? '0
                                                           : w_grant_idx + c_id_w'(1);
    assign w_sel_a    = req_a[int'(w_grant_idx)*W +: W];
    assign w_sel_b    = req_b[int'(w_grant_idx)*W +: W];

    always_comb begin : p_rsp_dec
        w_rsp_onehot                   = '0;
        w_rsp_onehot[r_tag_id[MM_LAT]] = 1'b1;
    end

    always_ff @(posedge clk) begin : p_main
        if (rst) begin
            r_rr_ptr  <= '0;
            r_tag_vld <= '0;
            for (int s = 0; s <= MM_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
            mm_a      <= '0;
            mm_b      <= '0;
            rsp_valid <= '0;
            rsp_d     <= '0;
        end else begin
            if (w_xfer) begin
                mm_a     <= w_sel_a;
                mm_b     <= w_sel_b;
                r_rr_ptr <= w_next_ptr;
            end
            // The multiplier never stalls, so the tags shift every cycle.
            r_tag_vld   <= {r_tag_vld[MM_LAT-1:0], w_xfer};
            r_tag_id[0] <= w_grant_idx;
            for (int s = 1; s <= MM_LAT; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            if (r_tag_vld[MM_LAT]) begin
                rsp_valid <= w_rsp_onehot;
                rsp_d     <= mm_d;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

    assign idle = ~|r_tag_vld & ~|req_ready;

`ifdef MODMUL_ARB_PERF_EN
    logic [31:0] r_perf_issues;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin : p_perf
        if (rst) begin
            r_perf_issues <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_xfer && (r_perf_issues != 32'hFFFF_FFFF)) begin
                r_perf_issues <= r_perf_issues + 32'd1;
            end
            if ((|req_valid) && !(|req_ready) && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issues = r_perf_issues;
    assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_modmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modmul_arbiter
// Description : Directed self-checking bench for modmul_arbiter. A behavioural
//               MM_LAT-stage multiplier returns the low W bits of a*b; with
//               the small operands used here that equals the modular product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modmul_arbiter;

    localparam int NREQ   = 4;
    localparam int MM_LAT = 4;
    localparam int W      = 255;

    logic              clk;
    logic              rst;
    logic              issue_en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      mm_a;
    logic [W-1:0]      mm_b;
    logic [W-1:0]      mm_d;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_d;
    logic              idle;
`ifdef MODMUL_ARB_PERF_EN
    logic [31:0]       perf_issues;
    logic [31:0]       perf_stall;
`endif

    logic [W-1:0] a_arr [NREQ];
    logic [W-1:0] b_arr [NREQ];

    int n_cmp;
    int n_fail;

    modmul_arbiter #(.NREQ(NREQ), .MM_LAT(MM_LAT), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_d       (mm_d),
        .rsp_valid  (rsp_valid),
        .rsp_d      (rsp_d),
        .idle       (idle)
`ifdef MODMUL_ARB_PERF_EN
        ,
        .perf_issues(perf_issues),
        .perf_stall (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_arr[i];
            req_b[i*W +: W] = b_arr[i];
        end
    end

    // Behavioural multiplier: MM_LAT registers from mm_a/mm_b to mm_d.
    logic [2*W-1:0] mm_prod;
    logic [W-1:0]   mm_pipe [MM_LAT];
    assign mm_prod = {{W{1'b0}}, mm_a} * {{W{1'b0}}, mm_b};
    always @(posedge clk) begin
        mm_pipe[0] <= mm_prod[W-1:0];
        for (int s = 1; s < MM_LAT; s++) begin
            mm_pipe[s] <= mm_pipe[s-1];
        end
    end
    assign mm_d = mm_pipe[MM_LAT-1];

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; issue_en = 1'b1; req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = W'(i + 1);
            b_arr[i] = W'(10);
        end
        settle();
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b exp %b", req_ready, 4'b0000);
        end
        cyc(); cyc();
        n_cmp++;
        if (mm_a !== '0 || mm_b !== '0) begin
            n_fail++; $display("FAIL reset_mm: got a=%0h b=%0h exp 0 0", mm_a, mm_b);
        end
        n_cmp++;
        if (rsp_valid !== 4'b0000 || rsp_d !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b d=%0h exp 0000 0", rsp_valid, rsp_d);
        end
        n_cmp++;
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle: got %b exp 1", idle);
        end
        rst = 1'b0;
        settle();
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_ptr0: got %b exp %b", req_ready, 4'b0001);
        end
        req_valid = 4'b0000;
        settle();
    endtask

    task automatic test_round_robin;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            n_cmp++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", k, req_ready, 4'(1 << (k % 4)));
            end
            cyc();
        end
        req_valid = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_cmp++;
            if (rsp_valid !== 4'(1 << (k % 4)) || rsp_d !== W'(10 * ((k % 4) + 1))) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got v=%b d=%0d exp v=%b d=%0d",
                         k, rsp_valid, rsp_d, 4'(1 << (k % 4)), 10 * ((k % 4) + 1));
            end
        end
        cyc();
    endtask

    task automatic test_single;
        a_arr[1] = W'(2); b_arr[1] = W'(3);
        req_valid = 4'b0010;
        settle();
        n_cmp++;
        if (req_ready !== 4'b0010 || idle !== 1'b0) begin
            n_fail++; $display("FAIL single_grant: got rdy=%b idle=%b exp 0010 0", req_ready, idle);
        end
        cyc();
        req_valid = 4'b0000;
        n_cmp++;
        if (mm_a !== W'(2) || mm_b !== W'(3) || idle !== 1'b0) begin
            n_fail++; $display("FAIL single_issue: got a=%0d b=%0d idle=%b exp 2 3 0", mm_a, mm_b, idle);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_cmp++;
            if (rsp_valid !== 4'b0000) begin
                n_fail++; $display("FAIL single_early%0d: got %b exp 0000", k, rsp_valid);
            end
        end
        cyc();
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_d !== W'(6)) begin
            n_fail++; $display("FAIL single_rsp: got v=%b d=%0d exp 0010 6", rsp_valid, rsp_d);
        end
        cyc();
        n_cmp++;
        if (rsp_valid !== 4'b0000 || rsp_d !== W'(6) || idle !== 1'b1) begin
            n_fail++; $display("FAIL single_after: got v=%b d=%0d idle=%b exp 0000 6 1", rsp_valid, rsp_d, idle);
        end
    endtask

    task automatic test_issue_en;
        // rr_ptr is 2 here; requester 2 issues, moving it to 3.
        a_arr[2] = W'(5); b_arr[2] = W'(7);
        req_valid = 4'b0100;
        settle();
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL gate_pre: got %b exp 0100", req_ready);
        end
        cyc();
        issue_en = 1'b0; req_valid = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            settle();
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL gate_ready%0d: got %b exp 0000", k, req_ready);
            end
            cyc();
            if (k == 5) begin
                n_cmp++;
                if (rsp_valid !== 4'b0100 || rsp_d !== W'(35)) begin
                    n_fail++; $display("FAIL gate_drain: got v=%b d=%0d exp 0100 35", rsp_valid, rsp_d);
                end
            end
        end
        issue_en = 1'b1;
        settle();
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL gate_resume: got %b exp 1000", req_ready);
        end
        cyc();
        req_valid = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            cyc();
        end
        n_cmp++;
        if (rsp_valid !== 4'b1000 || rsp_d !== W'(40)) begin
            n_fail++; $display("FAIL gate_resume_rsp: got v=%b d=%0d exp 1000 40", rsp_valid, rsp_d);
        end
        cyc();
    endtask

    task automatic test_back_to_back;
        b_arr[2] = W'(1);
        for (int c = 1; c <= 14; c++) begin
            if (c <= 8) begin
                req_valid = 4'b0100;
                a_arr[2]  = W'(c);
            end else begin
                req_valid = 4'b0000;
            end
            settle();
            if (c <= 8) begin
                n_cmp++;
                if (req_ready !== 4'b0100) begin
                    n_fail++; $display("FAIL b2b_grant%0d: got %b exp 0100", c, req_ready);
                end
            end
            cyc();
            n_cmp++;
            if (c >= 6 && c <= 13) begin
                if (rsp_valid !== 4'b0100 || rsp_d !== W'(c - 5)) begin
                    n_fail++; $display("FAIL b2b_rsp%0d: got v=%b d=%0d exp 0100 %0d", c, rsp_valid, rsp_d, c - 5);
                end
            end else if (rsp_valid !== 4'b0000) begin
                n_fail++; $display("FAIL b2b_quiet%0d: got %b exp 0000", c, rsp_valid);
            end
        end
    endtask

    task automatic test_reset_midstream;
        // rr_ptr is 3: grants go 0, 1, 2.
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_cmp++;
            if (req_ready !== 4'(1 << k)) begin
                n_fail++; $display("FAIL rmid_grant%0d: got %b exp %b", k, req_ready, 4'(1 << k));
            end
            cyc();
        end
        req_valid = 4'b0000;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL rmid_idle: got %b exp 1", idle);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_cmp++;
            if (rsp_valid !== 4'b0000) begin
                n_fail++; $display("FAIL rmid_dropped%0d: got %b exp 0000", k, rsp_valid);
            end
        end
        req_valid = 4'b1111;
        settle();
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rmid_ptr: got %b exp 0001", req_ready);
        end
        a_arr[3] = W'(9); b_arr[3] = W'(9);
        req_valid = 4'b1000;
        settle();
        cyc();
        req_valid = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            cyc();
        end
        n_cmp++;
        if (rsp_valid !== 4'b1000 || rsp_d !== W'(81)) begin
            n_fail++; $display("FAIL rmid_new: got v=%b d=%0d exp 1000 81", rsp_valid, rsp_d);
        end
        cyc();
    endtask

`ifdef MODMUL_ARB_PERF_EN
    task automatic test_perf;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (perf_issues !== 32'd0 || perf_stall !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset: got %0d %0d exp 0 0", perf_issues, perf_stall);
        end
        issue_en = 1'b1; req_valid = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            cyc();
        end
        n_cmp++;
        if (perf_issues !== 32'd6 || perf_stall !== 32'd0) begin
            n_fail++; $display("FAIL perf_issue: got %0d %0d exp 6 0", perf_issues, perf_stall);
        end
        issue_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
        end
        n_cmp++;
        if (perf_issues !== 32'd6 || perf_stall !== 32'd3) begin
            n_fail++; $display("FAIL perf_stall: got %0d %0d exp 6 3", perf_issues, perf_stall);
        end
        req_valid = 4'b0000; issue_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_issue_en();
        test_back_to_back();
        test_reset_midstream();
`ifdef MODMUL_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
